cpu_host_loader: RTL and testbench

//  Host-side driver of the processor's external memory ports: addr_ext/wen_ext/ren_ext/wdata_ext
//  (instruction memory) and addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2 (data memory).

---
 rtl/cpu_host_pkg.sv | 26 ++
 rtl/host_len_counter.sv | 43 ++++
 rtl/cpu_host_loader.sv | 198 +++++++++++++++++++
 tb/tb_cpu_host_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_host_pkg.sv
// Shared state encoding and stream constants for the host-side memory loader.
package cpu_host_pkg;

    typedef enum logic [3:0] {
        StIdle, StILen, StILoad, StIVer, StDLen, StDLoad,
        StRLen, StRun, StXLen, StXRd, StXOut
    } host_state_e;

    localparam int unsigned HostAddrStep = 4;

    // Order of the four length headers within one command stream.
    localparam logic [1:0] HdrNi    = 2'd0;
    localparam logic [1:0] HdrNd    = 2'd1;
    localparam logic [1:0] HdrNrun  = 2'd2;
    localparam logic [1:0] HdrNdump = 2'd3;

    function automatic logic [1:0] hdr_field(input host_state_e s);
        case (s)
            StILen:  return HdrNi;
            StDLen:  return HdrNd;
            StRLen:  return HdrNrun;
            default: return HdrNdump;
        endcase
    endfunction

endpackage

// File: rtl/host_len_counter.sv
// Shared length/index counter: load, decrement, zero/last flags, depth clamp and a
// word index that saturates at the active depth.
module host_len_counter #(
    parameter int unsigned IdxW = 11
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_clamp,
    input  logic [31:0]     i_len,
    input  logic [31:0]     i_depth,
    output logic            o_zero,
    output logic            o_last,
    output logic            o_over,
    output logic            o_in_range,
    output logic [IdxW-1:0] o_idx
);

    logic [31:0]     r_rem;
    logic [IdxW-1:0] r_idx;

    assign o_over     = i_len > i_depth;
    assign o_in_range = 32'(r_idx) < i_depth;
    assign o_zero     = r_rem == 32'd0;
    assign o_last     = r_rem == 32'd1;
    assign o_idx      = r_idx;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rem <= '0;
            r_idx <= '0;
        end else if (i_load) begin
            r_rem <= (i_clamp && o_over) ? i_depth : i_len;
            r_idx <= '0;
        end else if (i_step) begin
            r_rem <= r_rem - 32'd1;
            // Oversized loads keep consuming words; the index parks at depth so no write lands.
            if (o_in_range) r_idx <= r_idx + IdxW'(1);
        end
    end

endmodule

// File: rtl/cpu_host_loader.sv
// Host loader: fills imem/dmem from a command stream, runs the CPU, dumps a dmem region.
// Optional imem readback check is enabled by defining HOST_IMEM_VERIFY_EN.
module cpu_host_loader
    import cpu_host_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter int unsigned ADDR_STEP  = HostAddrStep
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              cpu_rst_n,
    output logic              cpu_enable,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2,
    output logic              busy,
    output logic              err_len,
    output logic              err_verify
);

    localparam int unsigned MaxWords = (IMEM_WORDS > DMEM_WORDS) ? IMEM_WORDS : DMEM_WORDS;
    localparam int unsigned IdxW     = $clog2(MaxWords) + 1;
`ifdef HOST_IMEM_VERIFY_EN
    localparam bit VerifyEn = 1'b1;
`else
    localparam bit VerifyEn = 1'b0;
`endif

    host_state_e       r_state;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_err_len;

    logic              w_cnt_load, w_cnt_step, w_cnt_clamp;
    logic [31:0]       w_cnt_len, w_depth, w_idx_addr;
    logic              w_zero, w_last, w_over, w_in_range;
    logic [IdxW-1:0]   w_idx;
    logic              w_len_state, w_in_fire;
    logic [1:0]        w_field;

    assign w_len_state = r_state inside {StILen, StDLen, StRLen, StXLen};
    assign in_ready    = w_len_state || r_state == StILoad || r_state == StDLoad;
    assign w_in_fire   = in_valid && in_ready;
    assign w_field     = hdr_field(r_state);
    assign w_depth     = (r_state inside {StILen, StILoad, StIVer}) ? 32'(IMEM_WORDS)
                                                                   : 32'(DMEM_WORDS);
    assign w_idx_addr  = 32'(w_idx) * 32'(ADDR_STEP);

`ifdef HOST_IMEM_VERIFY_EN
    logic [31:0]       r_ni;
    logic [DATA_W-1:0] r_acc;
    logic              r_ver_ph;
    logic              r_err_verify;
`endif

    always_comb begin
        w_cnt_load  = 1'b0;
        w_cnt_step  = 1'b0;
        w_cnt_clamp = 1'b0;
        w_cnt_len   = 32'(in_data);
        if (w_len_state && w_in_fire) begin
            w_cnt_load  = 1'b1;
            w_cnt_clamp = w_field == HdrNdump;
        end else if ((r_state == StILoad || r_state == StDLoad) && w_in_fire) begin
            w_cnt_step = 1'b1;
        end else if (r_state == StRun && !w_zero) begin
            w_cnt_step = 1'b1;
        end else if (r_state == StXOut && r_out_valid && out_ready) begin
            w_cnt_step = 1'b1;
        end
`ifdef HOST_IMEM_VERIFY_EN
        if (r_state == StIVer && r_ver_ph) w_cnt_step = 1'b1;
        // Last imem word: rearm the counter for the readback pass.
        if (r_state == StILoad && w_in_fire && w_last) begin
            w_cnt_load  = 1'b1;
            w_cnt_step  = 1'b0;
            w_cnt_len   = r_ni;
            w_cnt_clamp = 1'b1;
        end
`endif
    end

    host_len_counter #(
        .IdxW (IdxW)
    ) u_len_counter (
        .i_clk      (clk),
        .i_rst_n    (arst_n),
        .i_load     (w_cnt_load),
        .i_step     (w_cnt_step),
        .i_clamp    (w_cnt_clamp),
        .i_len      (w_cnt_len),
        .i_depth    (w_depth),
        .o_zero     (w_zero),
        .o_last     (w_last),
        .o_over     (w_over),
        .o_in_range (w_in_range),
        .o_idx      (w_idx)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err_len   <= 1'b0;
        end else begin
            if (w_len_state && w_in_fire && w_over && w_field != HdrNrun) r_err_len <= 1'b1;
            unique case (r_state)
                StIdle:  r_state <= StILen;
                StILen:  if (w_in_fire) r_state <= (w_cnt_len == 32'd0) ? StDLen : StILoad;
                StILoad: if (w_in_fire && w_last) r_state <= VerifyEn ? StIVer : StDLen;
`ifdef HOST_IMEM_VERIFY_EN
                StIVer:  if (r_ver_ph && w_last) r_state <= StDLen;
`endif
                StDLen:  if (w_in_fire) r_state <= (w_cnt_len == 32'd0) ? StRLen : StDLoad;
                StDLoad: if (w_in_fire && w_last) r_state <= StRLen;
                StRLen:  if (w_in_fire) r_state <= StRun;
                StRun:   if (w_zero) r_state <= StXLen;
                StXLen:  if (w_in_fire) r_state <= (w_cnt_len == 32'd0) ? StIdle : StXRd;
                StXRd:   r_state <= StXOut;
                StXOut: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= rdata_ext_2;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_last ? StIdle : StXRd;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef HOST_IMEM_VERIFY_EN
    // XOR of everything written, cancelled by everything read back; nonzero means a bad word.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_ni         <= '0;
            r_acc        <= '0;
            r_ver_ph     <= 1'b0;
            r_err_verify <= 1'b0;
        end else begin
            if (r_state == StILen && w_in_fire) begin
                r_ni  <= 32'(in_data);
                r_acc <= '0;
            end
            if (wen_ext) r_acc <= r_acc ^ in_data;
            if (r_state == StIVer) begin
                r_ver_ph <= !r_ver_ph;
                if (r_ver_ph) begin
                    r_acc <= r_acc ^ rdata_ext;
                    if (w_last && (r_acc ^ rdata_ext) != '0) r_err_verify <= 1'b1;
                end
            end else begin
                r_ver_ph <= 1'b0;
            end
        end
    end
    assign ren_ext    = r_state == StIVer && !r_ver_ph;
    assign err_verify = r_err_verify;
`else
    logic [DATA_W-1:0] w_unused_rdata;
    assign w_unused_rdata = rdata_ext;
    assign ren_ext        = 1'b0;
    assign err_verify     = 1'b0;
`endif

    assign wen_ext     = r_state == StILoad && w_in_fire && w_in_range;
    assign wdata_ext   = (r_state == StILoad) ? in_data : '0;
    assign addr_ext    = (r_state == StILoad || r_state == StIVer) ? w_idx_addr : '0;
    assign wen_ext_2   = r_state == StDLoad && w_in_fire && w_in_range;
    assign wdata_ext_2 = (r_state == StDLoad) ? in_data : '0;
    assign addr_ext_2  = (r_state == StDLoad || r_state == StXRd) ? w_idx_addr : '0;
    assign ren_ext_2   = r_state == StXRd;
    assign cpu_rst_n   = r_state inside {StRun, StXLen, StXRd, StXOut};
    assign cpu_enable  = r_state == StRun && !w_zero;
    assign busy        = r_state != StIdle;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign err_len     = r_err_len;

endmodule

// File: tb/tb_cpu_host_loader.sv
// Directed bench for cpu_host_loader with behavioural imem/dmem models.
module tb_cpu_host_loader;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        cpu_rst_n, cpu_enable;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] rdata_ext = '0;
    logic [31:0] rdata_ext_2 = '0;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic        busy, err_len, err_verify;

    always #5 clk = ~clk;

    cpu_host_loader u_dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .cpu_rst_n   (cpu_rst_n),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .busy        (busy),
        .err_len     (err_len),
        .err_verify  (err_verify)
    );

    logic [31:0] imem [512];
    logic [31:0] dmem [1024];
    logic        corrupt_w1 = 1'b0;

    always @(posedge clk) begin
        if (wen_ext && addr_ext < 32'd2048)
            imem[addr_ext[10:2]] <= (corrupt_w1 && addr_ext == 32'd4) ? wdata_ext ^ 32'h1
                                                                       : wdata_ext;
        if (wen_ext_2 && addr_ext_2 < 32'd4096) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
        if (ren_ext) rdata_ext <= imem[addr_ext[10:2]];
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor samples mid-low-phase, well clear of the active edge.
    logic [31:0] wen_addr_q [$];
    logic [31:0] out_q [$];
    int          bad_wen = 0, en_cnt = 0, ren_cnt = 0, stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        rand_ready = 1'b0;

    always @(negedge clk) begin
        #2;
        if (wen_ext) begin
            wen_addr_q.push_back(addr_ext);
            if (addr_ext >= 32'd2048) bad_wen++;
        end
        if (cpu_enable) en_cnt++;
        if (ren_ext) ren_cnt++;
        if (prev_stall && (!out_valid || out_data !== prev_data)) stall_err++;
        if (out_valid && out_ready) out_q.push_back(out_data);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    end

    always @(negedge clk) out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic clear_mon();
        wen_addr_q.delete();
        out_q.delete();
        bad_wen   = 0;
        en_cnt    = 0;
        stall_err = 0;
    endtask

    task automatic send(input logic [31:0] w);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_eq("in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (busy && n < 5000);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1 [3];
        t1 = '{32'h20010005, 32'h20020007, 32'h00221820};

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check_eq("rst_cpu_enable", 32'(cpu_enable), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_err_len", 32'(err_len), 32'd0);
        check_eq("rst_err_verify", 32'(err_verify), 32'd0);
        check_eq("rst_wen_ext", 32'(wen_ext), 32'd0);
        check_eq("rst_addr_ext", addr_ext, 32'd0);
        check_eq("rst_ren_ext_2", 32'(ren_ext_2), 32'd0);
        arst_n = 1'b1;

        // Test 1: three imem words, three run cycles
        clear_mon();
        send(32'd3);
        for (int i = 0; i < 3; i++) send(t1[i]);
        send(32'd0);
        send(32'd3);
        send(32'd0);
        wait_idle("t1");
        check_eq("t1_nwen", 32'(wen_addr_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t1_addr%0d", i), wen_addr_q[i], 32'(i * 4));
            check_eq($sformatf("t1_imem%0d", i), imem[i], t1[i]);
        end
        check_eq("t1_en_cycles", 32'(en_cnt), 32'd3);
        check_eq("t1_err_len", 32'(err_len), 32'd0);

        // Test 2: dmem load and dump, no run cycles
        clear_mon();
        send(32'd0);
        send(32'd2);
        send(32'hDEADBEEF);
        send(32'h00000001);
        send(32'd0);
        send(32'd2);
        wait_idle("t2");
        check_eq("t2_nout", 32'(out_q.size()), 32'd2);
        check_eq("t2_out0", out_q[0], 32'hDEADBEEF);
        check_eq("t2_out1", out_q[1], 32'h00000001);
        check_eq("t2_en_cycles", 32'(en_cnt), 32'd0);

        // Test 3: oversized imem load is clamped but fully consumed
        clear_mon();
        send(32'd513);
        for (int i = 0; i < 513; i++) send(32'h00010000 + 32'(i));
        send(32'd0);
        send(32'd2);
        send(32'd1);
        wait_idle("t3");
        check_eq("t3_err_len", 32'(err_len), 32'd1);
        check_eq("t3_nwen", 32'(wen_addr_q.size()), 32'd512);
        check_eq("t3_bad_wen", 32'(bad_wen), 32'd0);
        check_eq("t3_imem511", imem[511], 32'h000101FF);
        check_eq("t3_en_cycles", 32'(en_cnt), 32'd2);
        check_eq("t3_nout", 32'(out_q.size()), 32'd1);
        check_eq("t3_out0", out_q[0], 32'hDEADBEEF);

        // Test 4: dump under random backpressure
        clear_mon();
        send(32'd0);
        send(32'd4);
        for (int i = 0; i < 4; i++) send(32'hA5A50000 + 32'(i));
        send(32'd1);
        rand_ready = 1'b1;
        send(32'd4);
        wait_idle("t4");
        rand_ready = 1'b0;
        check_eq("t4_nout", 32'(out_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t4_out%0d", i), out_q[i], 32'hA5A50000 + 32'(i));
        check_eq("t4_stall_stable", 32'(stall_err), 32'd0);
        check_eq("t4_en_cycles", 32'(en_cnt), 32'd1);

        // Test 5: reset during dmem load, then a fresh stream
        clear_mon();
        send(32'd0);
        send(32'd5);
        send(32'h0000AAAA);
        send(32'h0000BBBB);
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        #2;
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_in_ready", 32'(in_ready), 32'd0);
        check_eq("t5_wen_ext_2", 32'(wen_ext_2), 32'd0);
        check_eq("t5_addr_ext_2", addr_ext_2, 32'd0);
        check_eq("t5_err_len", 32'(err_len), 32'd0);
        check_eq("t5_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        arst_n = 1'b1;
        send(32'd1);
        send(32'h11111111);
        send(32'd2);
        send(32'h00000022);
        send(32'h00000033);
        send(32'd0);
        send(32'd2);
        wait_idle("t5");
        check_eq("t5_imem0", imem[0], 32'h11111111);
        check_eq("t5_nout", 32'(out_q.size()), 32'd2);
        check_eq("t5_out0", out_q[0], 32'h00000022);
        check_eq("t5_out1", out_q[1], 32'h00000033);
        check_eq("t5_err_verify", 32'(err_verify), 32'd0);

        // Test 6: imem readback
`ifdef HOST_IMEM_VERIFY_EN
        corrupt_w1 = 1'b1;
        send(32'd3);
        send(32'h00000101);
        send(32'h00000202);
        send(32'h00000303);
        send(32'd0);
        send(32'd0);
        send(32'd0);
        wait_idle("t6");
        check_eq("t6_ren_seen", 32'(ren_cnt > 0), 32'd1);
        check_eq("t6_err_verify", 32'(err_verify), 32'd1);
`else
        check_eq("t6_ren_ext_cnt", 32'(ren_cnt), 32'd0);
        check_eq("t6_err_verify", 32'(err_verify), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
